// File: rtl/board_pkg.sv
// Shared constants and types for the board RAM token word and the board reader FSM.
package board_pkg;

    localparam int CELL_W  = 4;
    localparam int TOK_W   = 2;
    localparam int OCC_BIT = 9;
    localparam int TOK_LSB = 0;
    localparam int CNT_W   = 5;

    typedef logic [TOK_W-1:0] tok_id_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        OUT,
        FIN
    } rd_state_t;

endpackage

// File: rtl/board_reader_counterwe.sv
// Up-counter with synchronous clear and enable; clear takes priority over enable.
module counterwe #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/board_reader.sv
// Scans the board RAM once per start pulse and streams each decoded cell over valid/ready,
// reporting the number of occupied cells when the scan completes.
module board_reader
    import board_pkg::*;
#(
    parameter int N_CELLS = 16,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 10,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] addr_ram_board,
    input  logic [DATA_W-1:0] bus_data_i_ram_board,
    output logic              tok_valid,
    input  logic              tok_ready,
    output logic [3:0]        tok_cell,
    output logic [1:0]        tok_id,
    output logic              tok_occupied,
    output logic              busy,
    output logic              done,
    output logic [4:0]        occ_count
);

    rd_state_t          state_q, state_d;
    logic [1:0]         lat_q, lat_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]   occ_count_q, occ_count_d;
    logic               tok_valid_q, tok_valid_d;
    logic [CELL_W-1:0]  tok_cell_q, tok_cell_d;
    tok_id_t            tok_id_q, tok_id_d;
    logic               tok_occ_q, tok_occ_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CELL_W-1:0]  cell_idx;
    logic               accept;
    logic               last_cell;
    logic               idx_clr;
    logic               idx_en;
    logic               unused_word_bits;

    assign accept    = (state_q == OUT) && tok_valid_q && tok_ready;
    assign last_cell = (cell_idx == CELL_W'(N_CELLS - 1));
    assign idx_clr   = (state_q == IDLE) && start;
    // The index stays on the last cell after the final accept; only a new start rewinds it.
    assign idx_en    = accept && !last_cell;

    assign unused_word_bits = ^bus_data_i_ram_board[OCC_BIT-1:TOK_LSB+TOK_W];

    counterwe #(.W(CELL_W)) u_cell_idx (
        .clk   (clk),
        .rst   (rst),
        .clr   (idx_clr),
        .en    (idx_en),
        .count (cell_idx)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        run_cnt_d   = run_cnt_q;
        occ_count_d = occ_count_q;
        tok_valid_d = tok_valid_q;
        tok_cell_d  = tok_cell_q;
        tok_id_d    = tok_id_q;
        tok_occ_d   = tok_occ_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ADDR;
                    run_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ADDR: begin
                lat_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == 2'(RD_LAT - 1)) begin
                    tok_cell_d  = cell_idx;
                    tok_id_d    = bus_data_i_ram_board[TOK_LSB +: TOK_W];
                    tok_occ_d   = bus_data_i_ram_board[OCC_BIT];
                    tok_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            OUT: begin
                if (accept) begin
                    tok_valid_d = 1'b0;
                    run_cnt_d   = run_cnt_q + {{(CNT_W-1){1'b0}}, tok_occ_q};
                    if (last_cell) begin
                        // Publish the final count together with the done pulse.
                        occ_count_d = run_cnt_d;
                        done_d      = 1'b1;
                        state_d     = FIN;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            run_cnt_q   <= '0;
            occ_count_q <= '0;
            tok_valid_q <= 1'b0;
            tok_cell_q  <= '0;
            tok_id_q    <= '0;
            tok_occ_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            run_cnt_q   <= run_cnt_d;
            occ_count_q <= occ_count_d;
            tok_valid_q <= tok_valid_d;
            tok_cell_q  <= tok_cell_d;
            tok_id_q    <= tok_id_d;
            tok_occ_q   <= tok_occ_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign addr_ram_board = ADDR_W'(cell_idx);
    assign tok_valid      = tok_valid_q;
    assign tok_cell       = tok_cell_q;
    assign tok_id         = tok_id_q;
    assign tok_occupied   = tok_occ_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign occ_count      = occ_count_q;

endmodule
